// File: rtl/gene_collector_pkg.sv
// Shared NEAT definitions for the gene collector slice.
// Holds the gene word geometry: default widths and the bit offsets of the
// genome_id, type, src and dest attribute fields. Also holds the three-lane
// valid-mask encodings and a lane-count helper.
package gene_collector_pkg;

  localparam int unsigned GENE_SZ_DEF = 64;
  localparam int unsigned ATTR_SZ_DEF = 8;

  // Each attribute field is ATTR_SZ_DEF bits wide, packed from bit 0 upward.
  localparam int unsigned DEST_LSB      = 0;
  localparam int unsigned SRC_LSB       = DEST_LSB + ATTR_SZ_DEF;
  localparam int unsigned TYPE_LSB      = SRC_LSB + ATTR_SZ_DEF;
  localparam int unsigned GENOME_ID_LSB = TYPE_LSB + ATTR_SZ_DEF;

  // One bit per mutation lane: bit0 = lane1, bit1 = lane2, bit2 = lane3.
  localparam logic [2:0] LANE_NONE = 3'b000;
  localparam logic [2:0] LANE_1    = 3'b001;
  localparam logic [2:0] LANE_2    = 3'b010;
  localparam logic [2:0] LANE_3    = 3'b100;
  localparam logic [2:0] LANE_ALL  = 3'b111;

  function automatic logic [1:0] lane_popcount(input logic [2:0] mask);
    return {1'b0, mask[0]} + {1'b0, mask[1]} + {1'b0, mask[2]};
  endfunction

endpackage

// File: rtl/gene_lane_compact.sv
// Lane compaction for the gene collector.
// Maps a three-lane valid mask to the slot offset of each lane relative to the
// write pointer, so valid lanes land in consecutive slots in lane order.
//   mask_i     : lane-valid mask
//   lane_off_o : per-lane slot offset (meaningful only for valid lanes)
//   push_cnt_o : number of valid lanes, 0..3
//   top_lane_o : one-hot marker of the highest-numbered valid lane
module gene_lane_compact
  import gene_collector_pkg::*;
(
  input  logic [2:0]      mask_i,
  output logic [2:0][1:0] lane_off_o,
  output logic [1:0]      push_cnt_o,
  output logic [2:0]      top_lane_o
);

  always_comb begin
    lane_off_o[0] = 2'd0;
    lane_off_o[1] = {1'b0, mask_i[0]};
    lane_off_o[2] = {1'b0, mask_i[0]} + {1'b0, mask_i[1]};
    push_cnt_o    = lane_popcount(mask_i);

    top_lane_o = LANE_NONE;
    if (mask_i[2])      top_lane_o = LANE_3;
    else if (mask_i[1]) top_lane_o = LANE_2;
    else if (mask_i[0]) top_lane_o = LANE_1;
  end

endmodule

// File: rtl/gene_collector.sv
// Gene collector: gathers up to three mutation-lane genes per beat into a
// first-word-fall-through FIFO and serializes them one per cycle.
//   clk, rst (async, active-low), setup (sync flush)
//   in_valid/gene_in1..3/in_last/in_ready : input beat handshake
//   gene_out/out_valid/out_last/out_ready : serialized output handshake
//   gene_count     : genes emitted so far in the current genome
//   overflow       : sticky, a beat was dropped while in_ready was low
//   err_empty_last : one-cycle pulse for in_last with an empty lane mask
module gene_collector
  import gene_collector_pkg::*;
#(
  parameter int unsigned GENE_SZ = GENE_SZ_DEF,
  parameter int unsigned ATTR_SZ = ATTR_SZ_DEF,
  parameter int unsigned DEPTH   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               setup,
  input  logic [2:0]         in_valid,
  input  logic [GENE_SZ-1:0] gene_in1,
  input  logic [GENE_SZ-1:0] gene_in2,
  input  logic [GENE_SZ-1:0] gene_in3,
  input  logic               in_last,
  output logic               in_ready,
  output logic [GENE_SZ-1:0] gene_out,
  output logic               out_valid,
  output logic               out_last,
  input  logic               out_ready,
  output logic [ATTR_SZ-1:0] gene_count,
  output logic               overflow,
  output logic               err_empty_last
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  // Room for a full three-lane beat means count <= DEPTH-3.
  localparam logic [CW-1:0] ROOM_LIM = CW'(DEPTH - 3);

  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic [ATTR_SZ-1:0] gcnt_q, gcnt_d;
  logic               ovf_q, ovf_d;
  logic               err_q, err_d;

  // Entry layout: {last, gene}.
  logic [GENE_SZ:0]   mem_q [DEPTH];

  logic [2:0][1:0]         lane_off;
  logic [1:0]              push_cnt;
  logic [2:0]              top_lane;
  logic [2:0][GENE_SZ-1:0] lane_gene;
  logic [2:0]              lane_last;
  logic                    push, pop;
  logic [GENE_SZ:0]        head;

  gene_lane_compact u_compact (
    .mask_i     (in_valid),
    .lane_off_o (lane_off),
    .push_cnt_o (push_cnt),
    .top_lane_o (top_lane)
  );

  always_comb begin
    lane_gene = {gene_in3, gene_in2, gene_in1};
    lane_last = top_lane & {3{in_last}};

    in_ready  = rst && !setup && (count_q <= ROOM_LIM);
    push      = in_ready && (in_valid != LANE_NONE);
    out_valid = (count_q != '0);
    pop       = out_valid && out_ready;

    // Storage is not reset, so the head is masked whenever the FIFO is empty.
    head       = mem_q[rd_ptr_q];
    gene_out   = out_valid ? head[GENE_SZ-1:0] : '0;
    out_last   = out_valid && head[GENE_SZ];
    gene_count = gcnt_q;
    overflow   = ovf_q;
    err_empty_last = err_q;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q + (push ? AW'(push_cnt) : '0);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q + (push ? CW'(push_cnt) : '0) - CW'(pop);
    gcnt_d   = gcnt_q;
    if (pop) gcnt_d = out_last ? '0 : gcnt_q + ATTR_SZ'(1);
    ovf_d    = ovf_q || (!in_ready && (in_valid != LANE_NONE));
    err_d    = in_last && (in_valid == LANE_NONE);

    // setup wins over push and pop (push is already blocked via in_ready).
    if (setup) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      gcnt_d   = '0;
      ovf_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      gcnt_q   <= '0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      gcnt_q   <= gcnt_d;
      ovf_q    <= ovf_d;
      err_q    <= err_d;
    end
  end

  // Valid lanes are written to consecutive slots; wrap comes from AW-bit math.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < 3; i++) begin
      if (push && in_valid[i]) begin
        mem_q[wr_ptr_q + AW'(lane_off[i])] <= {lane_last[i], lane_gene[i]};
      end
    end
  end

endmodule

// File: tb/tb_gene_collector.sv
module tb_gene_collector;

  localparam int unsigned GSZ   = 64;
  localparam int unsigned ASZ   = 8;
  localparam int unsigned DEPTH = 8;

  logic           clk = 1'b0;
  logic           rst, setup;
  logic [2:0]     in_valid;
  logic [GSZ-1:0] gene_in1, gene_in2, gene_in3;
  logic           in_last, in_ready;
  logic [GSZ-1:0] gene_out;
  logic           out_valid, out_last, out_ready;
  logic [ASZ-1:0] gene_count;
  logic           overflow, err_empty_last;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  // Scoreboard entries are {last, gene}.
  logic [GSZ:0]   sb[$];
  logic [ASZ-1:0] gc_m = '0;
  logic           ov_m = 1'b0;

  gene_collector #(.GENE_SZ(GSZ), .ATTR_SZ(ASZ), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .setup          (setup),
    .in_valid       (in_valid),
    .gene_in1       (gene_in1),
    .gene_in2       (gene_in2),
    .gene_in3       (gene_in3),
    .in_last        (in_last),
    .in_ready       (in_ready),
    .gene_out       (gene_out),
    .out_valid      (out_valid),
    .out_last       (out_last),
    .out_ready      (out_ready),
    .gene_count     (gene_count),
    .overflow       (overflow),
    .err_empty_last (err_empty_last)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Output monitor: each DUT pop is compared against the scoreboard head.
  always @(negedge clk) begin
    logic [GSZ:0] e;
    if (rst === 1'b1 && setup === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_pop", 64'(gene_out), 64'hDEAD);
      end else begin
        e = sb.pop_front();
        check("gene_out", gene_out, e[GSZ-1:0]);
        check("out_last", 64'(out_last), 64'(e[GSZ]));
        check("gene_count", 64'(gene_count), 64'(gc_m));
        gc_m = e[GSZ] ? '0 : gc_m + ASZ'(1);
      end
    end
  end

  // Called at posedge+1; returns at the next posedge+1 with inputs idled.
  task automatic beat(input logic [2:0] m, input logic [GSZ-1:0] g1, input logic [GSZ-1:0] g2,
                      input logic [GSZ-1:0] g3, input logic l);
    logic       exp_rdy;
    logic [2:0] top;
    in_valid = m; gene_in1 = g1; gene_in2 = g2; gene_in3 = g3; in_last = l;
    #1;
    exp_rdy = !setup && (sb.size() <= int'(DEPTH - 3));
    check("in_ready", 64'(in_ready), 64'(exp_rdy));
    top = m[2] ? 3'b100 : m[1] ? 3'b010 : m[0] ? 3'b001 : 3'b000;
    if (exp_rdy) begin
      if (m[0]) sb.push_back({l && top[0], g1});
      if (m[1]) sb.push_back({l && top[1], g2});
      if (m[2]) sb.push_back({l && top[2], g3});
    end else if (m != 3'b000) begin
      ov_m = 1'b1;
    end
    @(posedge clk); #1;
    in_valid = 3'b000; in_last = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 60 && sb.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    check("drain_left", 64'(sb.size()), 64'd0);
    check("empty_after_drain", 64'(out_valid), 64'd0);
    check("gene_count_idle", 64'(gene_count), 64'(gc_m));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; setup = 1'b0; in_valid = 3'b000; in_last = 1'b0; out_ready = 1'b0;
    gene_in1 = '0; gene_in2 = '0; gene_in3 = '0;
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_gene_out", gene_out, 64'd0);
    check("rst_out_last", 64'(out_last), 64'd0);
    check("rst_gene_count", 64'(gene_count), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    check("rst_err", 64'(err_empty_last), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;

    // Full three-lane genome streamed straight out.
    out_ready = 1'b1;
    beat(3'b111, 64'hA0A0_0000_0000_000A, 64'hB0B0_0000_0000_000B, 64'hC0C0_0000_0000_000C, 1'b1);
    drain();

    // Sparse mask 101: lane2 skipped.
    beat(3'b101, 64'h1111_0000_0000_0001, 64'hFFFF_FFFF_FFFF_FFFF, 64'h3333_0000_0000_0003, 1'b0);
    drain();

    // Fill with out_ready low, drop a beat, then drain in order.
    out_ready = 1'b0;
    beat(3'b111, 64'h10, 64'h11, 64'h12, 1'b0);
    beat(3'b111, 64'h13, 64'h14, 64'h15, 1'b0);
    beat(3'b111, 64'h16, 64'h17, 64'h18, 1'b0);
    check("overflow_set", 64'(overflow), 64'(ov_m));
    check("stall_gene_a", gene_out, sb[0][GSZ-1:0]);
    @(posedge clk); #1;
    check("stall_gene_b", gene_out, sb[0][GSZ-1:0]);
    drain();
    check("overflow_sticky", 64'(overflow), 64'(ov_m));

    // in_last with an empty mask.
    beat(3'b000, 64'h99, 64'h99, 64'h99, 1'b1);
    check("err_pulse", 64'(err_empty_last), 64'd1);
    check("err_no_entry", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    check("err_one_cycle", 64'(err_empty_last), 64'd0);

    // setup flush with data queued and a partial genome counted.
    out_ready = 1'b0;
    beat(3'b011, 64'h21, 64'h22, 64'h0, 1'b0);
    setup = 1'b1;
    #1 check("setup_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    setup = 1'b0;
    sb.delete(); gc_m = '0; ov_m = 1'b0;
    check("setup_overflow", 64'(overflow), 64'd0);
    check("setup_gene_count", 64'(gene_count), 64'd0);
    check("setup_out_valid", 64'(out_valid), 64'd0);

    // Long single-lane stream across several pointer wraps.
    out_ready = 1'b1;
    for (int i = 0; i < 3 * int'(DEPTH); i++) begin
      beat(3'b001, 64'h1000 + 64'(i), 64'h0, 64'h0, i == 3 * int'(DEPTH) - 1);
    end
    drain();

    // Reset asserted with five entries queued.
    out_ready = 1'b0;
    beat(3'b111, 64'h31, 64'h32, 64'h33, 1'b0);
    beat(3'b011, 64'h34, 64'h35, 64'h0, 1'b0);
    rst = 1'b0;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_gene_out", gene_out, 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd0);
    sb.delete(); gc_m = '0; ov_m = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    beat(3'b001, 64'h7777_0000_0000_0077, 64'h0, 64'h0, 1'b1);
    drain();
    check("post_rst_overflow", 64'(overflow), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/gene_collector.md
GENE_COLLECTOR -- requirements
Module: gene_collector

Interface
REQ-001 SHALL have parameter GENE_SZ, default 64, meaning gene word width in bits.
REQ-002 SHALL have parameter ATTR_SZ, default 8, meaning width of one gene attribute field and of gene_count.
REQ-003 SHALL have parameter DEPTH, default 8, meaning FIFO entries; legal values are powers of two and at least 4.
REQ-004 SHALL have ports:
  clk  input  1  sole clock, rising edge.
  rst  input  1  asynchronous, active-low reset.
  setup  input  1  synchronous flush.
  in_valid  input  3  lane-valid mask; bit0 = lane1, bit1 = lane2, bit2 = lane3.
  gene_in1, gene_in2, gene_in3  input  GENE_SZ  mutation-lane genes.
  in_last  input  1  the current beat closes the genome.
  in_ready  output  1  collector accepts a beat this cycle.
  gene_out  output  GENE_SZ  serialized gene.
  out_valid  output  1  gene_out holds valid data.
  out_last  output  1  gene_out is the final gene of its genome.
  out_ready  input  1  downstream accepts gene_out.
  gene_count  output  ATTR_SZ  genes emitted so far in the current genome.
  overflow  output  1  sticky flag: a beat was dropped.
  err_empty_last  output  1  one-cycle pulse: in_last arrived with in_valid == 0.

Function
REQ-005 SHALL assert in_ready combinationally when free entries >= 3 and setup is low.
REQ-006 SHALL accept a beat when in_ready is high and in_valid is non-zero, writing the valid lanes in lane order 1, 2, 3 into consecutive FIFO slots and skipping invalid lanes (mask 101 writes two entries: lane1, then lane3).
REQ-007 SHALL tag only the highest-numbered valid lane of an accepted beat with last = in_last.
REQ-008 SHALL drop a beat with non-zero in_valid that arrives while in_ready is low, and set overflow, which holds until rst or setup.
REQ-009 SHALL pulse err_empty_last for one cycle when in_last = 1 with in_valid = 000, and write nothing.
REQ-010 SHALL operate as first-word-fall-through: out_valid = (count != 0), gene_out and out_last are taken from the read-pointer entry, and a gene written at edge N is visible after edge N.
REQ-011 SHALL pop one entry per cycle when out_valid and out_ready are both high; gene_out SHALL stay stable while out_valid is high and out_ready is low.
REQ-012 SHALL support a push of up to 3 entries and a pop of 1 entry in the same cycle, with count updated as count + pushed - popped.
REQ-013 SHALL use read and write pointers of width log2(DEPTH) that wrap modulo DEPTH, and a count of width log2(DEPTH)+1.
REQ-014 SHALL increment gene_count by 1 on each pop without last, and clear it to 0 on a pop with last; gene_count SHALL wrap modulo 2^ATTR_SZ.
REQ-015 SHALL give setup = 1 priority over push and pop: on the next edge it clears the pointers, count, gene_count and overflow, and it deasserts in_ready during the cycle setup is asserted.

Reset
REQ-016 SHALL, while rst = 0, force: in_ready = 0, out_valid = 0, out_last = 0, gene_out = 0, gene_count = 0, overflow = 0, err_empty_last = 0, pointers = 0, count = 0.
REQ-017 SHALL discard all in-flight data on reset assertion mid-stream, including a partially emitted genome, and resume empty on the first edge after release.
REQ-018 SHALL NOT reset FIFO storage contents, because out_valid gates them.

Structure
REQ-019 SHALL place the gene field offsets (genome_id, type, src, dest), GENE_SZ and ATTR_SZ defaults, and the lane-mask encodings in the shared NEAT package.
REQ-020 SHALL implement the lane compaction (mask to write-slot offsets and push count 0-3) as one combinational sub-module, gene_lane_compact.

Verification
REQ-021 SHALL cover this scenario: mask 111 with genes A, B, C and in_last = 1, out_ready held high -> outputs A, B, C on three consecutive cycles, out_last = 1 only on C, gene_count 0 -> 1 -> 2 -> 0.
REQ-022 SHALL cover this scenario: mask 101 with genes X, -, Z -> outputs X then Z, count returns to 0.
REQ-023 SHALL cover this scenario: DEPTH = 8, out_ready = 0, beats of mask 111 pushed until full -> in_ready drops when count reaches 6; a further beat is dropped, overflow = 1, and the 6 stored genes drain in order.
REQ-024 SHALL cover this scenario: continuous mask 001 pushes with out_ready = 1 across more than 2*DEPTH beats -> pointer wrap occurs with no loss or reorder, and count stays at 1 or below.
REQ-025 SHALL cover this scenario: in_last = 1 with mask 000 -> err_empty_last pulses once, and no entry or count change occurs.
REQ-026 SHALL cover this scenario: rst pulsed low while 5 entries are queued -> out_valid = 0 immediately, and after release a new beat is the first gene out.
